// File: rtl/alu_op_encoder_pkg.sv
// alu_op_pkg: shared definitions for the ALU-control encoder slice.
//   - 4-bit ALU operation codes (OP_*), OP_ILLEGAL marks an unsupported encoding
//   - aluop_e: instruction class coming from the main decoder
//   - F7_BASE / F7_ALT: the two funct7 patterns that select operation variants
package alu_op_pkg;

   localparam logic [3:0] OP_AND     = 4'b0000;
   localparam logic [3:0] OP_OR      = 4'b0001;
   localparam logic [3:0] OP_ADD     = 4'b0010;
   localparam logic [3:0] OP_SUB     = 4'b0011;
   localparam logic [3:0] OP_SRL     = 4'b0100;
   localparam logic [3:0] OP_SRA     = 4'b0101;
   localparam logic [3:0] OP_BEQ     = 4'b1000;
   localparam logic [3:0] OP_BLT     = 4'b1001;
   localparam logic [3:0] OP_ILLEGAL = 4'b1111;

   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_RTYPE  = 2'b10,
      ALUOP_ITYPE  = 2'b11
   } aluop_e;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_op_encoder_decode.sv
// alu_op_decode: combinational map of {ALUOp, funct3, funct7} to an ALU
// operation code. Any combination without a defined operation yields
// OP_ILLEGAL with illegal=1.
//   aluop     in  [1:0]  instruction class
//   funct3    in  [2:0]  instruction funct3
//   funct7    in  [6:0]  instruction funct7 / imm[11:5]
//   operation out [3:0]  ALU operation code
//   illegal   out        encoding has no defined operation
module alu_op_decode
   import alu_op_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] operation,
   output logic       illegal
);

   always_comb begin
      operation = OP_ILLEGAL;
      case (aluop_e'(aluop))
         ALUOP_MEM: operation = OP_ADD;
         ALUOP_BRANCH: begin
            case (funct3)
               3'b000:  operation = OP_BEQ;
               3'b100:  operation = OP_BLT;
               default: ;
            endcase
         end
         ALUOP_RTYPE: begin
            case (funct3)
               3'b000: begin
                  if (funct7 == F7_BASE)     operation = OP_ADD;
                  else if (funct7 == F7_ALT) operation = OP_SUB;
               end
               3'b111: if (funct7 == F7_BASE) operation = OP_AND;
               3'b110: if (funct7 == F7_BASE) operation = OP_OR;
               3'b101: begin
                  if (funct7 == F7_BASE)     operation = OP_SRL;
                  else if (funct7 == F7_ALT) operation = OP_SRA;
               end
               default: ;
            endcase
         end
         ALUOP_ITYPE: begin
            case (funct3)
               3'b000: operation = OP_ADD;
               3'b111: operation = OP_AND;
               3'b110: operation = OP_OR;
               3'b101: begin
                  if (funct7 == F7_BASE)     operation = OP_SRL;
                  else if (funct7 == F7_ALT) operation = OP_SRA;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
      // Every defined path overwrites the default, so the code itself tells
      // whether the encoding was recognised.
      illegal = (operation == OP_ILLEGAL);
   end

endmodule

// File: rtl/alu_op_encoder.sv
// alu_op_encoder: registered ALU-control stage at the ID/EX boundary.
// Decodes {ALUOp, Funct3, Funct7} into the ALU operation code and holds it
// for EX under a valid/ready handshake with stall and flush. Accepted illegal
// encodings are counted in a saturating counter cleared only by reset.
// Optional build macro ALU_OP_SKID_EN adds a one-entry skid buffer so that
// id_ready is registered and independent of ex_stall.
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   id_valid       in   ID presents a decoded instruction
//   id_ready       out  stage can accept this cycle
//   ALUOp          in   [1:0] instruction class
//   Funct3, Funct7 in   instruction function fields
//   ex_stall       in   EX cannot consume the held operation
//   flush          in   kill held (and skid) entry and the incoming one
//   ex_valid       out  Operation is valid for EX
//   Operation      out  [OPCODE_LENGTH-1:0] ALU operation code
//   illegal        out  held operation was an illegal encoding
//   illegal_count  out  [CNT_WIDTH-1:0] accepted illegal encodings, saturating
module alu_op_encoder
   import alu_op_pkg::*;
#(
   parameter int OPCODE_LENGTH = 4,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     id_valid,
   output logic                     id_ready,
   input  logic [1:0]               ALUOp,
   input  logic [2:0]               Funct3,
   input  logic [6:0]               Funct7,
   input  logic                     ex_stall,
   input  logic                     flush,
   output logic                     ex_valid,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     illegal,
   output logic [CNT_WIDTH-1:0]     illegal_count
);

   logic [3:0] dec_op;
   logic       dec_ill;
   logic       accept;

   alu_op_decode u_decode (
      .aluop     (ALUOp),
      .funct3    (Funct3),
      .funct7    (Funct7),
      .operation (dec_op),
      .illegal   (dec_ill)
   );

   assign accept = id_valid && id_ready;

`ifdef ALU_OP_SKID_EN
   logic       skid_valid;
   logic [3:0] skid_op;
   logic       skid_ill;
   logic       out_free;

   assign id_ready = !skid_valid;
   assign out_free = !ex_valid || !ex_stall;

   // The skid can only be full while the output is held, and id_ready is low
   // whenever the skid is full, so a skid drain never coincides with an accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         Operation  <= '0;
         illegal    <= 1'b0;
         skid_valid <= 1'b0;
         skid_op    <= '0;
         skid_ill   <= 1'b0;
      end else if (flush) begin
         ex_valid   <= 1'b0;
         skid_valid <= 1'b0;
      end else if (out_free) begin
         if (skid_valid) begin
            ex_valid   <= 1'b1;
            Operation  <= OPCODE_LENGTH'(skid_op);
            illegal    <= skid_ill;
            skid_valid <= 1'b0;
         end else if (accept) begin
            ex_valid  <= 1'b1;
            Operation <= OPCODE_LENGTH'(dec_op);
            illegal   <= dec_ill;
         end else begin
            ex_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_op    <= dec_op;
         skid_ill   <= dec_ill;
      end
   end
`else
   assign id_ready = !ex_valid || !ex_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         Operation <= '0;
         illegal   <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid  <= 1'b1;
         Operation <= OPCODE_LENGTH'(dec_op);
         illegal   <= dec_ill;
      end else if (id_ready) begin
         ex_valid <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_count <= '0;
      end else if (accept && dec_ill && !flush && (illegal_count != '1)) begin
         illegal_count <= illegal_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_alu_op_encoder.sv
// Self-checking bench for alu_op_encoder. Directed vectors push their
// hand-computed result into a queue; a monitor pops and compares whenever EX
// consumes the held operation. Build with ALU_OP_SKID_EN to exercise the skid.
module tb_alu_op_encoder;

   localparam logic [6:0] F7B = 7'b0000000;
   localparam logic [6:0] F7A = 7'b0100000;
`ifdef ALU_OP_SKID_EN
   localparam logic SKID = 1'b1;
`else
   localparam logic SKID = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic       id_ready;
   logic [1:0] ALUOp = 2'b00;
   logic [2:0] Funct3 = 3'b000;
   logic [6:0] Funct7 = 7'b0000000;
   logic       ex_stall = 1'b0;
   logic       flush = 1'b0;
   logic       ex_valid;
   logic [3:0] Operation;
   logic       illegal;
   logic [1:0] illegal_count;

   int checks = 0;
   int errors = 0;
   logic [4:0] exp_q[$];

   alu_op_encoder #(.OPCODE_LENGTH(4), .CNT_WIDTH(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_ready      (id_ready),
      .ALUOp         (ALUOp),
      .Funct3        (Funct3),
      .Funct7        (Funct7),
      .ex_stall      (ex_stall),
      .flush         (flush),
      .ex_valid      (ex_valid),
      .Operation     (Operation),
      .illegal       (illegal),
      .illegal_count (illegal_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the next rising edge.
   task automatic step(input logic v, input logic [1:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic st, input logic fl,
                       input logic exp_rdy, input logic [3:0] eop, input logic eill);
      id_valid = v; ALUOp = op; Funct3 = f3; Funct7 = f7; ex_stall = st; flush = fl;
      #1;
      chk("id_ready", 32'(id_ready), 32'(exp_rdy));
      if (fl) exp_q.delete();
      else if (v && exp_rdy) exp_q.push_back({eop, eill});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic st, input logic exp_rdy);
      step(1'b0, 2'b00, 3'b000, F7B, st, 1'b0, exp_rdy, 4'h0, 1'b0);
   endtask

   // EX consumes the held operation on an edge where it is valid and not stalled.
   always @(negedge clk) begin
      if (rst_n && ex_valid && !ex_stall && !flush) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output: got op=%b ill=%b expected no output at %0t",
                     Operation, illegal, $time);
         end else begin
            chk("scoreboard_op_ill", 32'({Operation, illegal}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ex_valid", 32'(ex_valid), 0);
      chk("reset_operation", 32'(Operation), 0);
      chk("reset_illegal", 32'(illegal), 0);
      chk("reset_count", 32'(illegal_count), 0);
      rst_n = 1'b1;

      // First edge after reset release accepts SUB.
      step(1, 2'b10, 3'b000, F7A, 0, 0, 1, 4'b0011, 0);
      chk("first_accept_valid", 32'(ex_valid), 1);
      chk("first_accept_op", 32'(Operation), 32'(4'b0011));

      // SRA then stall for three cycles with AND presented.
      step(1, 2'b11, 3'b101, F7A, 0, 0, 1, 4'b0101, 0);
`ifdef ALU_OP_SKID_EN
      step(1, 2'b11, 3'b111, F7B, 1, 0, 1, 4'b0000, 0);
      chk("stall_hold_op", 32'(Operation), 32'(4'b0101));
      step(1, 2'b11, 3'b111, F7B, 1, 0, 0, 4'b0000, 0);
      chk("stall_hold_op", 32'(Operation), 32'(4'b0101));
      step(1, 2'b11, 3'b111, F7B, 1, 0, 0, 4'b0000, 0);
      chk("stall_hold_op", 32'(Operation), 32'(4'b0101));
      idle(0, 0);
`else
      for (int i = 0; i < 3; i++) begin
         step(1, 2'b11, 3'b111, F7B, 1, 0, 0, 4'b0000, 0);
         chk("stall_hold_op", 32'(Operation), 32'(4'b0101));
         chk("stall_hold_valid", 32'(ex_valid), 1);
      end
      step(1, 2'b11, 3'b111, F7B, 0, 0, 1, 4'b0000, 0);
`endif
      chk("after_stall_op", 32'(Operation), 32'(4'b0000));

      // Illegal branch funct3.
      step(1, 2'b01, 3'b010, F7B, 0, 0, 1, 4'b1111, 1);
      chk("illegal_op", 32'(Operation), 32'(4'b1111));
      chk("illegal_flag", 32'(illegal), 1);
      chk("illegal_count_1", 32'(illegal_count), 1);

      // Flush while stalled with an illegal instruction presented.
      step(1, 2'b01, 3'b011, F7B, 1, 1, SKID, 4'h0, 0);
      chk("flush_stall_valid", 32'(ex_valid), 0);
      chk("flush_stall_count", 32'(illegal_count), 1);
      chk("flush_stall_op_kept", 32'(Operation), 32'(4'b1111));

      // Flush coincident with an accepted illegal instruction.
      step(1, 2'b01, 3'b000, F7B, 0, 0, 1, 4'b1000, 0);
      step(1, 2'b01, 3'b111, F7B, 0, 1, 1, 4'h0, 0);
      chk("flush_accept_valid", 32'(ex_valid), 0);
      chk("flush_accept_count", 32'(illegal_count), 1);
      chk("flush_accept_op_kept", 32'(Operation), 32'(4'b1000));

      // Empty cycle after a valid one.
      step(1, 2'b00, 3'b111, 7'b1111111, 0, 0, 1, 4'b0010, 0);
      idle(0, 1);
      chk("empty_valid", 32'(ex_valid), 0);
      chk("empty_op_kept", 32'(Operation), 32'(4'b0010));

      // Saturation of the 2-bit counter.
      step(1, 2'b10, 3'b000, 7'b0000001, 0, 0, 1, 4'b1111, 1);
      chk("count_2", 32'(illegal_count), 2);
      step(1, 2'b01, 3'b001, F7B, 0, 0, 1, 4'b1111, 1);
      chk("count_3", 32'(illegal_count), 3);
      step(1, 2'b11, 3'b001, F7B, 0, 0, 1, 4'b1111, 1);
      chk("count_sat", 32'(illegal_count), 3);
      step(1, 2'b10, 3'b100, F7B, 0, 0, 1, 4'b1111, 1);
      chk("count_sat", 32'(illegal_count), 3);

      // Legal decode table and remaining illegal corners.
      step(1, 2'b01, 3'b000, F7A, 0, 0, 1, 4'b1000, 0);
      step(1, 2'b01, 3'b100, F7B, 0, 0, 1, 4'b1001, 0);
      step(1, 2'b10, 3'b110, F7B, 0, 0, 1, 4'b0001, 0);
      step(1, 2'b10, 3'b101, F7B, 0, 0, 1, 4'b0100, 0);
      step(1, 2'b10, 3'b111, F7B, 0, 0, 1, 4'b0000, 0);
      step(1, 2'b10, 3'b000, F7B, 0, 0, 1, 4'b0010, 0);
      step(1, 2'b10, 3'b101, F7A, 0, 0, 1, 4'b0101, 0);
      step(1, 2'b10, 3'b111, F7A, 0, 0, 1, 4'b1111, 1);
      step(1, 2'b11, 3'b000, 7'b1111111, 0, 0, 1, 4'b0010, 0);
      step(1, 2'b11, 3'b110, F7A, 0, 0, 1, 4'b0001, 0);
      step(1, 2'b11, 3'b111, F7A, 0, 0, 1, 4'b0000, 0);
      step(1, 2'b11, 3'b101, F7B, 0, 0, 1, 4'b0100, 0);
      step(1, 2'b11, 3'b101, 7'b0000001, 0, 0, 1, 4'b1111, 1);

      // Asynchronous reset while stalled.
      step(1, 2'b11, 3'b101, F7A, 0, 0, 1, 4'b0101, 0);
      id_valid = 1'b0;
      ex_stall = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(ex_valid), 0);
      chk("async_rst_op", 32'(Operation), 0);
      chk("async_rst_illegal", 32'(illegal), 0);
      chk("async_rst_count", 32'(illegal_count), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

`ifdef ALU_OP_SKID_EN
      // Two accepts under stall: ADD to output, BEQ to skid.
      step(1, 2'b00, 3'b000, F7B, 1, 0, 1, 4'b0010, 0);
      step(1, 2'b01, 3'b000, F7B, 1, 0, 1, 4'b1000, 0);
      chk("skid_full_ready", 32'(id_ready), 0);
      idle(1, 0);
      chk("skid_hold_add", 32'(Operation), 32'(4'b0010));
      idle(0, 0);
      chk("skid_drain_beq", 32'(Operation), 32'(4'b1000));
      chk("skid_drain_valid", 32'(ex_valid), 1);
      idle(0, 1);
      chk("skid_empty_valid", 32'(ex_valid), 0);
`else
      idle(0, 1);
`endif

      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
